// File: rtl/uart_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Byte-level command controller behind a UART receiver.
//               Assembles 5-byte frames (A5, CMD, ADDR, DATA, CHK), checks
//               them, runs one register-bus read or write, and returns one
//               response byte per frame through the transmitter handshake.
// Ports       : clk, rst_n               - clock, async active-low reset
//               rx_data/rx_valid/rx_ready - receiver byte stream + pacing
//               reg_wr/reg_rd/reg_addr/reg_wdata/reg_rdata/reg_ack
//                                         - internal register bus
//               tx_data/tx_valid/tx_ready - response byte to transmitter
//               err_cnt                   - saturating rejected-frame count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int BYTE_TIMEOUT = CLK_FREQ / BAUD_RATE * 40,
  parameter int BUS_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] c_sync   = 8'hA5;
  localparam logic [7:0] c_cmd_wr = 8'h01;
  localparam logic [7:0] c_cmd_rd = 8'h02;
  localparam logic [7:0] c_ack    = 8'h06;
  localparam logic [7:0] c_nak    = 8'h15;

  localparam int c_byte_w = $clog2(BYTE_TIMEOUT + 1);
  localparam int c_bus_w  = $clog2(BUS_TIMEOUT + 1);
  // Counters hold the number of idle cycles already elapsed; the cycle on
  // which the counter reads LAST is the final allowed one.
  localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(BYTE_TIMEOUT - 1);
  localparam logic [c_bus_w-1:0]  c_bus_last  = c_bus_w'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_BUS  = 3'd5,
    ST_RESP = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          reg_addr_q, reg_addr_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;
  logic                reg_wr_q, reg_wr_d;
  logic                reg_rd_q, reg_rd_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                rx_ready_q, rx_ready_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [c_byte_w-1:0] byte_cnt_q, byte_cnt_d;
  logic [c_bus_w-1:0]  bus_cnt_q, bus_cnt_d;
  logic                err_inc;
  logic                chk_ok;
  logic                cmd_ok;

  assign chk_ok = (rx_data == (cmd_q ^ reg_addr_q ^ reg_wdata_q));
  assign cmd_ok = (cmd_q == c_cmd_wr) || (cmd_q == c_cmd_rd);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = reg_wr_q;
    reg_rd_d    = reg_rd_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    err_cnt_d   = err_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    bus_cnt_d   = bus_cnt_q;
    err_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == c_sync)) begin
          state_d    = ST_CMD;
          byte_cnt_d = '0;
        end
      end

      ST_CMD, ST_ADDR, ST_DATA, ST_CHK: begin
        // A byte on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          byte_cnt_d = '0;
          case (state_q)
            ST_CMD: begin
              cmd_d   = rx_data;
              state_d = ST_ADDR;
            end
            ST_ADDR: begin
              reg_addr_d = rx_data;
              state_d    = ST_DATA;
            end
            ST_DATA: begin
              reg_wdata_d = rx_data;
              state_d     = ST_CHK;
            end
            default: begin
              if (chk_ok && cmd_ok) begin
                state_d   = ST_BUS;
                bus_cnt_d = '0;
                reg_wr_d  = (cmd_q == c_cmd_wr);
                reg_rd_d  = (cmd_q == c_cmd_rd);
              end else begin
                state_d    = ST_RESP;
                tx_data_d  = c_nak;
                tx_valid_d = 1'b1;
                err_inc    = 1'b1;
              end
            end
          endcase
        end else if (byte_cnt_q == c_byte_last) begin
          state_d    = ST_IDLE;
          byte_cnt_d = '0;
          err_inc    = 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q + c_byte_w'(1);
        end
      end

      ST_BUS: begin
        // Ack is checked first so it beats a simultaneous timeout.
        if (reg_ack) begin
          state_d    = ST_RESP;
          reg_wr_d   = 1'b0;
          reg_rd_d   = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = reg_wr_q ? c_ack : reg_rdata;
        end else if (bus_cnt_q == c_bus_last) begin
          state_d    = ST_RESP;
          reg_wr_d   = 1'b0;
          reg_rd_d   = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = c_nak;
          err_inc    = 1'b1;
        end else begin
          bus_cnt_d = bus_cnt_q + c_bus_w'(1);
        end
      end

      ST_RESP: begin
        if (tx_ready) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    // Registered from the next state so the pin tracks the state exactly.
    rx_ready_d = !((state_d == ST_BUS) || (state_d == ST_RESP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b1;
      err_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      bus_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
      err_cnt_q   <= err_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Directed testbench for uart_cmd_ctrl. Expected response
//               bytes are queued by the stimulus; a monitor pops and compares
//               them on every tx handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] err_cnt;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  uart_cmd_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All driving and direct sampling happens 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(addr);
    send_byte(data);
    send_byte(chk);
  endtask

  // Scoreboard monitor: one pop per accepted response byte.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got=%0h expected=none", tx_data);
      end else begin
        check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (reg_wr || reg_rd)) begin
      check("req_exclusive", {31'h0, reg_wr & reg_rd}, 32'h0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic ok;

    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    reg_rdata = 8'h00;
    reg_ack   = 1'b0;
    tx_ready  = 1'b1;
    repeat (3) tick();
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_reg_wr", {31'h0, reg_wr}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Write, acked on the third request cycle.
    exp_q.push_back(8'h06);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    check("wr_c1", {31'h0, reg_wr}, 32'h1);
    check("wr_no_rd", {31'h0, reg_rd}, 32'h0);
    check("wr_addr", {24'h0, reg_addr}, 32'h10);
    check("wr_wdata", {24'h0, reg_wdata}, 32'h3C);
    check("wr_rx_ready", {31'h0, rx_ready}, 32'h0);
    tick();
    check("wr_c2", {31'h0, reg_wr}, 32'h1);
    tick();
    check("wr_c3", {31'h0, reg_wr}, 32'h1);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    check("wr_drop", {31'h0, reg_wr}, 32'h0);
    check("wr_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("wr_tx_data", {24'h0, tx_data}, 32'h06);
    tick();
    check("wr_tx_done", {31'h0, tx_valid}, 32'h0);
    check("wr_rx_ready_back", {31'h0, rx_ready}, 32'h1);
    check("wr_err", {24'h0, err_cnt}, 32'h0);

    // Read, acked on the first request cycle.
    exp_q.push_back(8'h5A);
    send_frame(8'h02, 8'h20, 8'h00, 8'h22);
    check("rd_req", {31'h0, reg_rd}, 32'h1);
    check("rd_no_wr", {31'h0, reg_wr}, 32'h0);
    check("rd_addr", {24'h0, reg_addr}, 32'h20);
    reg_rdata = 8'h5A;
    reg_ack   = 1'b1;
    tick();
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    check("rd_drop", {31'h0, reg_rd}, 32'h0);
    check("rd_tx_data", {24'h0, tx_data}, 32'h5A);
    tick();

    // Bad checksum.
    exp_q.push_back(8'h15);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
    check("badchk_no_wr", {31'h0, reg_wr}, 32'h0);
    check("badchk_no_rd", {31'h0, reg_rd}, 32'h0);
    check("badchk_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("badchk_err", {24'h0, err_cnt}, 32'h1);
    tick();

    // Good checksum, unknown command.
    exp_q.push_back(8'h15);
    send_frame(8'h07, 8'h01, 8'h02, 8'h04);
    check("badcmd_no_req", {31'h0, reg_wr | reg_rd}, 32'h0);
    check("badcmd_err", {24'h0, err_cnt}, 32'h2);
    tick();

    // Garbage dropped, then inter-byte timeout without a response.
    send_byte(8'h00);
    send_byte(8'hFF);
    check("garbage_err", {24'h0, err_cnt}, 32'h2);
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (17359) tick();
    check("tmo_not_yet", {24'h0, err_cnt}, 32'h2);
    check("tmo_rx_ready", {31'h0, rx_ready}, 32'h1);
    tick();
    check("tmo_err", {24'h0, err_cnt}, 32'h3);
    check("tmo_no_tx", {31'h0, tx_valid}, 32'h0);
    exp_q.push_back(8'h06);
    send_frame(8'h01, 8'h55, 8'hAA, 8'hFE);
    check("after_tmo_wr", {31'h0, reg_wr}, 32'h1);
    check("after_tmo_addr", {24'h0, reg_addr}, 32'h55);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    tick();

    // Byte arriving exactly on the timeout-expiry cycle is consumed.
    exp_q.push_back(8'h77);
    send_byte(8'hA5);
    repeat (17359) tick();
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h22);
    check("edge_rd_req", {31'h0, reg_rd}, 32'h1);
    check("edge_err", {24'h0, err_cnt}, 32'h3);
    reg_rdata = 8'h77;
    reg_ack   = 1'b1;
    tick();
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    tick();

    // Bus timeout with transmitter backpressure.
    tx_ready = 1'b0;
    exp_q.push_back(8'h15);
    send_frame(8'h01, 8'h44, 8'h99, 8'hDC);
    n = 0;
    while (reg_wr && n < 400) begin
      n++;
      tick();
    end
    check("bus_tmo_len", n, 32'd255);
    check("bus_tmo_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("bus_tmo_tx_data", {24'h0, tx_data}, 32'h15);
    check("bus_tmo_err", {24'h0, err_cnt}, 32'h4);
    ok = 1'b1;
    repeat (50) begin
      if (!(tx_valid && tx_data == 8'h15 && !rx_ready && !reg_wr)) ok = 1'b0;
      tick();
    end
    check("bp_hold", {31'h0, ok}, 32'h1);
    tx_ready = 1'b1;
    tick();
    check("bp_tx_done", {31'h0, tx_valid}, 32'h0);
    check("bp_rx_ready", {31'h0, rx_ready}, 32'h1);

    // Reset while a write is in flight; a late ack is ignored.
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    tick();
    check("mid_bus_wr", {31'h0, reg_wr}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_wr", {31'h0, reg_wr}, 32'h0);
    check("arst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("arst_addr", {24'h0, reg_addr}, 32'h0);
    check("arst_wdata", {24'h0, reg_wdata}, 32'h0);
    check("arst_tx_data", {24'h0, tx_data}, 32'h0);
    check("arst_err", {24'h0, err_cnt}, 32'h0);
    tick();
    rst_n   = 1'b1;
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    check("late_ack_tx", {31'h0, tx_valid}, 32'h0);
    check("late_ack_wr", {31'h0, reg_wr}, 32'h0);
    tick();
    exp_q.push_back(8'hC3);
    send_frame(8'h02, 8'h33, 8'h00, 8'h31);
    check("post_rst_rd", {31'h0, reg_rd}, 32'h1);
    check("post_rst_addr", {24'h0, reg_addr}, 32'h33);
    reg_rdata = 8'hC3;
    reg_ack   = 1'b1;
    tick();
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    check("post_rst_tx", {24'h0, tx_data}, 32'hC3);
    tick();
    check("post_rst_err", {24'h0, err_cnt}, 32'h0);

    // Error counter saturation: 256 rejected frames.
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'h15);
      send_frame(8'h01, 8'h00, 8'h00, 8'h00);
      tick();
    end
    check("err_saturate", {24'h0, err_cnt}, 32'hFF);

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
